pool_window_ctrl: RTL and testbench

//  Sequencer directly upstream of the max-pool stage. Accepts a job config (window length, window count),

---
 rtl/cnn_pkg.sv | 15 +
 rtl/pool_delay_line.sv | 33 +++
 rtl/pool_window_ctrl.sv | 124 ++++++++++++
 tb/tb_pool_window_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: sequencer state encoding, cfg widths and the pool-stage latency.
package cnn_pkg;

  localparam int unsigned CfgWidth    = 8;
  localparam int unsigned NumWidth    = 16;
  // Must track the max-pool stage's actual output latency.
  localparam int unsigned PoolLatency = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pool_delay_line.sv
// Depth-deep 1-bit marker shift register; pending_o flags a marker that has yet to reach out_o.
module pool_delay_line #(
  parameter int unsigned Depth = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic out_o,
  output logic pending_o
);

  localparam logic [Depth-1:0] OutMask = Depth'(1) << (Depth - 1);

  logic [Depth-1:0] stage_q, stage_d;

  always_comb begin
    stage_d    = stage_q << 1;
    stage_d[0] = in_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_o = stage_q[Depth-1];
  // The output stage is excluded: once a marker sits there, nothing remains after this cycle.
  assign pending_o = in_i | (|(stage_q & ~OutMask));

endmodule

// File: rtl/pool_window_ctrl.sv
// Window sequencer in front of the max-pool stage: registers samples, marks window boundaries,
// times win_done/job_done. Optional stat_windows counter under POOL_WINDOW_CTRL_STATS_EN.
module pool_window_ctrl
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_WIDTH    = NumWidth,
  parameter int unsigned CFG_WIDTH    = CfgWidth,
  parameter int unsigned POOL_LATENCY = PoolLatency
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CFG_WIDTH-1:0] cfg_len,
  input  logic [CFG_WIDTH-1:0] cfg_num,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [NUM_WIDTH-1:0] up_data,
  input  logic                 up_valid,
  output logic                 up_ready,
  output logic [NUM_WIDTH-1:0] pool_data,
  output logic                 pool_valid,
  output logic                 pool_restart,
  output logic                 win_done,
  output logic                 job_done
`ifdef POOL_WINDOW_CTRL_STATS_EN
  ,
  output logic [31:0]          stat_windows
`endif
);

  ctrl_state_e          state_q;
  logic [CFG_WIDTH-1:0] len_q, num_q, sample_cnt_q, win_cnt_q;
  logic [NUM_WIDTH-1:0] pool_data_q;
  logic                 pool_valid_q, pool_restart_q, mark_q, job_done_q;
  logic                 up_hs, last_sample, last_win, line_pending;

  assign cfg_ready   = (state_q == StIdle);
  assign up_ready    = (state_q == StRun);
  assign up_hs       = up_valid & up_ready;
  assign last_sample = (sample_cnt_q == len_q - CFG_WIDTH'(1));
  assign last_win    = (win_cnt_q == num_q - CFG_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      len_q          <= '0;
      num_q          <= '0;
      sample_cnt_q   <= '0;
      win_cnt_q      <= '0;
      pool_data_q    <= '0;
      pool_valid_q   <= 1'b0;
      pool_restart_q <= 1'b0;
      mark_q         <= 1'b0;
      job_done_q     <= 1'b0;
    end else begin
      pool_valid_q   <= up_hs;
      pool_data_q    <= up_hs ? up_data : '0;
      pool_restart_q <= up_hs && (sample_cnt_q == '0);
      // Marker travels with the last sample so the delay line counts from its pool_valid cycle.
      mark_q         <= up_hs && last_sample;
      job_done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_valid) begin
            len_q        <= (cfg_len == '0) ? CFG_WIDTH'(1) : cfg_len;
            num_q        <= (cfg_num == '0) ? CFG_WIDTH'(1) : cfg_num;
            sample_cnt_q <= '0;
            win_cnt_q    <= '0;
            state_q      <= StRun;
          end
        end
        StRun: begin
          if (up_hs) begin
            if (last_sample) begin
              sample_cnt_q <= '0;
              win_cnt_q    <= win_cnt_q + CFG_WIDTH'(1);
              if (last_win) begin
                state_q <= StDrain;
              end
            end else begin
              sample_cnt_q <= sample_cnt_q + CFG_WIDTH'(1);
            end
          end
        end
        StDrain: begin
          if (!mark_q && !line_pending) begin
            state_q    <= StIdle;
            job_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pool_delay_line #(
    .Depth(POOL_LATENCY)
  ) u_marker_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_i     (mark_q),
    .out_o    (win_done),
    .pending_o(line_pending)
  );

  assign pool_data    = pool_data_q;
  assign pool_valid   = pool_valid_q;
  assign pool_restart = pool_restart_q;
  assign job_done     = job_done_q;

`ifdef POOL_WINDOW_CTRL_STATS_EN
  logic [31:0] stat_windows_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_windows_q <= '0;
    end else if (win_done) begin
      stat_windows_q <= stat_windows_q + 32'd1;
    end
  end

  assign stat_windows = stat_windows_q;
`endif

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Directed self-checking bench for pool_window_ctrl with hand-derived timing expectations.
module tb_pool_window_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_len, cfg_num;
  logic        cfg_valid, cfg_ready;
  logic [15:0] up_data;
  logic        up_valid, up_ready;
  logic [15:0] pool_data;
  logic        pool_valid, pool_restart, win_done, job_done;
`ifdef POOL_WINDOW_CTRL_STATS_EN
  logic [31:0] stat_windows;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pool_window_ctrl u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_len     (cfg_len),
    .cfg_num     (cfg_num),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .up_data     (up_data),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .pool_data   (pool_data),
    .pool_valid  (pool_valid),
    .pool_restart(pool_restart),
    .win_done    (win_done),
    .job_done    (job_done)
`ifdef POOL_WINDOW_CTRL_STATS_EN
    ,
    .stat_windows(stat_windows)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] data_of(input int k);
    case (k)
      0:       return 16'd3;
      1:       return 16'hFFF9;  // -7
      2:       return 16'd9;
      3:       return 16'd2;
      default: return 16'(k * 977 + 11);
    endcase
  endfunction

  int wd_q[$];

  // win_done must be high exactly in the cycles queued (handshake cycle of a last sample + 5).
  task automatic check_wd();
    logic exp;
    exp = (wd_q.size() > 0) && (wd_q[0] == cyc);
    if (exp) void'(wd_q.pop_front());
    check_eq("win_done", {31'b0, win_done}, {31'b0, exp});
  endtask

  task automatic run_job(input int raw_len, input int raw_num, input bit gaps);
    int len, num, last_c, jd_cyc;
    len = (raw_len == 0) ? 1 : raw_len;
    num = (raw_num == 0) ? 1 : raw_num;
    cfg_len   = 8'(raw_len);
    cfg_num   = 8'(raw_num);
    cfg_valid = 1'b1;
    check_eq("cfg_ready_idle", {31'b0, cfg_ready}, 32'd1);
    step();
    cfg_valid = 1'b0;
    check_wd();
    last_c = cyc;
    for (int k = 0; k < len * num; k++) begin
      if (gaps) begin
        for (int n = 0; n < 3 && $urandom_range(0, 1) == 1; n++) begin
          up_valid = 1'b0;
          up_data  = 16'($urandom);
          step();
          check_wd();
          check_eq("bubble_valid", {31'b0, pool_valid}, 32'd0);
          check_eq("bubble_restart", {31'b0, pool_restart}, 32'd0);
          check_eq("bubble_data", {16'b0, pool_data}, 32'd0);
        end
      end
      up_valid = 1'b1;
      up_data  = data_of(k);
      check_eq("up_ready_run", {31'b0, up_ready}, 32'd1);
      check_eq("job_done_run", {31'b0, job_done}, 32'd0);
      if (k % len == len - 1) begin
        wd_q.push_back(cyc + 5);
        last_c = cyc;
      end
      step();
      check_wd();
      check_eq("pool_valid", {31'b0, pool_valid}, 32'd1);
      check_eq("pool_data", {16'b0, pool_data}, {16'b0, data_of(k)});
      check_eq("pool_restart", {31'b0, pool_restart}, {31'b0, (k % len) == 0});
    end
    up_valid = 1'b0;
    check_eq("up_ready_drain", {31'b0, up_ready}, 32'd0);
    jd_cyc = last_c + 6;
    while (cyc < jd_cyc) begin
      step();
      check_wd();
      check_eq("job_done", {31'b0, job_done}, {31'b0, cyc == jd_cyc});
      check_eq("cfg_ready_drain", {31'b0, cfg_ready}, {31'b0, cyc == jd_cyc});
    end
    check_eq("wd_all_seen", wd_q.size(), 32'd0);
    wd_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; cfg_len = '0; cfg_num = '0; cfg_valid = 1'b0; up_data = '0; up_valid = 1'b0;
    repeat (3) step();
    check_eq("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    check_eq("rst_up_ready", {31'b0, up_ready}, 32'd0);
    check_eq("rst_pool_data", {16'b0, pool_data}, 32'd0);
    check_eq("rst_pool_valid", {31'b0, pool_valid}, 32'd0);
    check_eq("rst_pool_restart", {31'b0, pool_restart}, 32'd0);
    check_eq("rst_win_done", {31'b0, win_done}, 32'd0);
    check_eq("rst_job_done", {31'b0, job_done}, 32'd0);
    rst_n = 1'b1;
    step();

    run_job(4, 1, 1'b0);
    run_job(2, 3, 1'b0);
    run_job(0, 0, 1'b0);
    run_job(3, 2, 1'b1);
    run_job(1, 3, 1'b0);
    run_job(255, 1, 1'b0);

    // Abort a job with a marker in flight.
    cfg_len = 8'd4; cfg_num = 8'd2; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      up_valid = 1'b1;
      up_data  = data_of(k);
      step();
    end
    up_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_pool_valid", {31'b0, pool_valid}, 32'd0);
    check_eq("midrst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("post_rst_win_done", {31'b0, win_done}, 32'd0);
      check_eq("post_rst_job_done", {31'b0, job_done}, 32'd0);
      check_eq("post_rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    end
    run_job(2, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
